sad_col_matcher: RTL and testbench

Column-serial block-matching stage directly downstream of the SRAM output formatter. Each valid column it takes the 4-pixel reference column and the 7-pixel search column and forms per-offset column SADs for 4 vertical displacements. It sums them over a sliding window of the last WIN columns and reports the minimum SAD, its vertical displacement and a still/motion flag. The co-sited noisy pixel is kept aligned for the downstream temporal filter.

---
 rtl/sad_col_matcher.sv | 167 ++++++++++++++++
 tb/tb_sad_col_matcher.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sad_col_matcher.sv
// Column-serial block matcher: per-offset column SADs summed over a sliding
// window of WIN columns, reporting the minimum, its vertical offset and a still flag.
module sad_col_matcher #(
    parameter int WIN = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_ref_vld,
    input  logic [7:0]  i_ref0,
    input  logic [7:0]  i_ref1,
    input  logic [7:0]  i_ref2,
    input  logic [7:0]  i_ref3,
    input  logic        i_srh_vld,
    input  logic [7:0]  i_srh0,
    input  logic [7:0]  i_srh1,
    input  logic [7:0]  i_srh2,
    input  logic [7:0]  i_srh3,
    input  logic [7:0]  i_srh4,
    input  logic [7:0]  i_srh5,
    input  logic [7:0]  i_srh6,
    input  logic        i_nsy_vld,
    input  logic [7:0]  i_nsy_pix,
    input  logic [11:0] i_sad_thr,
    output logic        o_sad_vld,
    output logic [11:0] o_sad_min,
    output logic [1:0]  o_mv_y,
    output logic        o_still,
    output logic [11:0] o_col_idx,
    output logic [7:0]  o_out_pix
);

    localparam logic [3:0] WIN_L  = 4'(WIN);
    localparam logic [3:0] WIN_M1 = 4'(WIN - 1);

    // Inputs are valid-only: a column is taken on every cycle all three valids
    // are high; there is no ready and the pipeline never stalls.
    logic       w_col_en;
    logic [7:0] w_ref [4];
    logic [7:0] w_srh [7];
    logic [9:0] w_p   [4];

    assign w_col_en = i_ref_vld & i_srh_vld & i_nsy_vld;

    assign w_ref[0] = i_ref0;
    assign w_ref[1] = i_ref1;
    assign w_ref[2] = i_ref2;
    assign w_ref[3] = i_ref3;
    assign w_srh[0] = i_srh0;
    assign w_srh[1] = i_srh1;
    assign w_srh[2] = i_srh2;
    assign w_srh[3] = i_srh3;
    assign w_srh[4] = i_srh4;
    assign w_srh[5] = i_srh5;
    assign w_srh[6] = i_srh6;

    function automatic logic [9:0] absd(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_p[k] = '0;
            for (int i = 0; i < 4; i++) begin
                w_p[k] = w_p[k] + absd(w_ref[i], w_srh[k+i]);
            end
        end
    end

    // Stage 1: column SADs
    logic       r_v1;
    logic [9:0] r_p [4];
    logic [7:0] r_pix1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_v1   <= 1'b0;
            r_pix1 <= '0;
            for (int k = 0; k < 4; k++) r_p[k] <= '0;
        end else begin
            r_v1 <= w_col_en;
            if (w_col_en) begin
                r_pix1 <= i_nsy_pix;
                for (int k = 0; k < 4; k++) r_p[k] <= w_p[k];
            end
        end
    end

    // Stage 2: sliding window sums; a stage-1 bubble wipes the window
    logic       r_v2;
    logic [9:0] r_hist [4][WIN];
    logic [11:0] r_w   [4];
    logic [3:0] r_fill;
    logic [7:0] r_pix2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_v2   <= 1'b0;
            r_fill <= '0;
            r_pix2 <= '0;
            for (int k = 0; k < 4; k++) begin
                r_w[k] <= '0;
                for (int j = 0; j < WIN; j++) r_hist[k][j] <= '0;
            end
        end else if (!r_v1) begin
            r_v2   <= 1'b0;
            r_fill <= '0;
            for (int k = 0; k < 4; k++) begin
                r_w[k] <= '0;
                for (int j = 0; j < WIN; j++) r_hist[k][j] <= '0;
            end
        end else begin
            r_v2   <= (r_fill >= WIN_M1);
            r_fill <= (r_fill == WIN_L) ? r_fill : r_fill + 4'd1;
            r_pix2 <= r_pix1;
            for (int k = 0; k < 4; k++) begin
                // Unfilled slots hold zero, so the evicted term is 0 until full.
                r_w[k] <= r_w[k] + {2'b00, r_p[k]} - {2'b00, r_hist[k][WIN-1]};
                r_hist[k][0] <= r_p[k];
                for (int j = 1; j < WIN; j++) r_hist[k][j] <= r_hist[k][j-1];
            end
        end
    end

    // Stage 3: argmin, lowest offset wins ties
    logic [11:0] w_min;
    logic [1:0]  w_arg;

    always_comb begin
        w_min = r_w[0];
        w_arg = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (r_w[k] < w_min) begin
                w_min = r_w[k];
                w_arg = 2'(k);
            end
        end
    end

    logic [11:0] r_idx_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx_cnt <= '0;
            o_sad_vld <= 1'b0;
            o_sad_min <= '0;
            o_mv_y    <= '0;
            o_still   <= 1'b0;
            o_col_idx <= '0;
            o_out_pix <= '0;
        end else begin
            o_sad_vld <= r_v2;
            if (r_v2) begin
                o_sad_min <= w_min;
                o_mv_y    <= w_arg;
                o_still   <= (w_min <= i_sad_thr);
                o_col_idx <= r_idx_cnt;
                o_out_pix <= r_pix2;
            end
            // The run-end bubble in stage 2 restarts numbering after any in-flight emit.
            if (!r_v1)
                r_idx_cnt <= '0;
            else if (r_v2)
                r_idx_cnt <= r_idx_cnt + 12'd1;
        end
    end

endmodule

// File: tb/tb_sad_col_matcher.sv
// Directed bench for sad_col_matcher (WIN=4): hand-computed SAD results
// checked cycle by cycle with immediate assertions.
module tb_sad_col_matcher;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_ref_vld, i_srh_vld, i_nsy_vld;
    logic [7:0]  i_ref0, i_ref1, i_ref2, i_ref3;
    logic [7:0]  i_srh0, i_srh1, i_srh2, i_srh3, i_srh4, i_srh5, i_srh6;
    logic [7:0]  i_nsy_pix;
    logic [11:0] i_sad_thr;
    logic        o_sad_vld;
    logic [11:0] o_sad_min;
    logic [1:0]  o_mv_y;
    logic        o_still;
    logic [11:0] o_col_idx;
    logic [7:0]  o_out_pix;

    always #5 clk = ~clk;

    sad_col_matcher #(.WIN(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_ref_vld(i_ref_vld), .i_ref0(i_ref0), .i_ref1(i_ref1), .i_ref2(i_ref2), .i_ref3(i_ref3),
        .i_srh_vld(i_srh_vld), .i_srh0(i_srh0), .i_srh1(i_srh1), .i_srh2(i_srh2), .i_srh3(i_srh3),
        .i_srh4(i_srh4), .i_srh5(i_srh5), .i_srh6(i_srh6),
        .i_nsy_vld(i_nsy_vld), .i_nsy_pix(i_nsy_pix), .i_sad_thr(i_sad_thr),
        .o_sad_vld(o_sad_vld), .o_sad_min(o_sad_min), .o_mv_y(o_mv_y), .o_still(o_still),
        .o_col_idx(o_col_idx), .o_out_pix(o_out_pix)
    );

    int errors = 0;
    int checks = 0;

    logic       st_en  [32];
    logic [7:0] st_ref [32][4];
    logic [7:0] st_srh [32][7];
    logic [7:0] st_pix [32];
    int ex_n = 0;
    int ex_tick [16];
    int ex_min  [16];
    int ex_mv   [16];
    int ex_st   [16];
    int ex_idx  [16];
    int ex_pix  [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int t = 0; t < 32; t++) st_en[t] = 1'b0;
        ex_n = 0;
    endtask

    task automatic set_cols(input int first, input int last,
                            input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3,
                            input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5,
                            input logic [7:0] s6);
        for (int t = first; t <= last; t++) begin
            st_en[t] = 1'b1;
            st_ref[t][0] = r0; st_ref[t][1] = r1; st_ref[t][2] = r2; st_ref[t][3] = r3;
            st_srh[t][0] = s0; st_srh[t][1] = s1; st_srh[t][2] = s2; st_srh[t][3] = s3;
            st_srh[t][4] = s4; st_srh[t][5] = s5; st_srh[t][6] = s6;
            st_pix[t] = 8'(t * 7 + 3);
        end
    endtask

    task automatic add_res(input int tk, input int mn, input int mv, input int st,
                           input int idx, input int pix);
        ex_tick[ex_n] = tk; ex_min[ex_n] = mn; ex_mv[ex_n] = mv;
        ex_st[ex_n] = st; ex_idx[ex_n] = idx; ex_pix[ex_n] = pix;
        ex_n++;
    endtask

    task automatic drive_col(input int t);
        i_ref_vld = 1'b1; i_srh_vld = 1'b1; i_nsy_vld = 1'b1;
        i_ref0 = st_ref[t][0]; i_ref1 = st_ref[t][1]; i_ref2 = st_ref[t][2]; i_ref3 = st_ref[t][3];
        i_srh0 = st_srh[t][0]; i_srh1 = st_srh[t][1]; i_srh2 = st_srh[t][2]; i_srh3 = st_srh[t][3];
        i_srh4 = st_srh[t][4]; i_srh5 = st_srh[t][5]; i_srh6 = st_srh[t][6];
        i_nsy_pix = st_pix[t];
    endtask

    // Only the noisy-pixel valid drops, so col_en must depend on all three.
    task automatic drive_idle();
        i_ref_vld = 1'b1; i_srh_vld = 1'b1; i_nsy_vld = 1'b0;
    endtask

    // Column t is sampled at tick t; its result is visible right after tick t+2.
    task automatic play(input int n, input string tag);
        int r = 0;
        for (int t = 0; t < n + 3; t++) begin
            if (t < n && st_en[t]) drive_col(t);
            else drive_idle();
            tick();
            if (r < ex_n && ex_tick[r] == t) begin
                chk($sformatf("%s.vld@%0d", tag, t), 32'(o_sad_vld), 1);
                chk($sformatf("%s.min@%0d", tag, t), 32'(o_sad_min), ex_min[r]);
                chk($sformatf("%s.mv@%0d", tag, t), 32'(o_mv_y), ex_mv[r]);
                chk($sformatf("%s.still@%0d", tag, t), 32'(o_still), ex_st[r]);
                chk($sformatf("%s.idx@%0d", tag, t), 32'(o_col_idx), ex_idx[r]);
                chk($sformatf("%s.pix@%0d", tag, t), 32'(o_out_pix), ex_pix[r]);
                r++;
            end else begin
                chk($sformatf("%s.vld@%0d", tag, t), 32'(o_sad_vld), 0);
            end
        end
        chk($sformatf("%s.count", tag), r, ex_n);
        clr();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vld"}, 32'(o_sad_vld), 0);
        chk({tag, ".min"}, 32'(o_sad_min), 0);
        chk({tag, ".mv"}, 32'(o_mv_y), 0);
        chk({tag, ".still"}, 32'(o_still), 0);
        chk({tag, ".idx"}, 32'(o_col_idx), 0);
        chk({tag, ".pix"}, 32'(o_out_pix), 0);
    endtask

    initial begin
        nrst = 1'b0;
        i_ref_vld = 1'b0; i_srh_vld = 1'b0; i_nsy_vld = 1'b0;
        i_ref0 = '0; i_ref1 = '0; i_ref2 = '0; i_ref3 = '0;
        i_srh0 = '0; i_srh1 = '0; i_srh2 = '0; i_srh3 = '0;
        i_srh4 = '0; i_srh5 = '0; i_srh6 = '0;
        i_nsy_pix = '0; i_sad_thr = '0;
        clr();
        tick(); tick();
        chk_zero("reset");
        nrst = 1'b1;
        tick();

        // Uniform match: all zero SADs, tie resolves to offset 0
        i_sad_thr = 12'd0;
        set_cols(0, 5, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100);
        add_res(5, 0, 0, 1, 0, 24);
        add_res(6, 0, 0, 1, 1, 31);
        add_res(7, 0, 0, 1, 2, 38);
        play(6, "uniform");

        // Displacement 2: p = 70,40,0,70 -> W = 280,160,0,280
        set_cols(0, 3, 10, 20, 30, 40, 0, 0, 10, 20, 30, 40, 0);
        add_res(5, 0, 2, 1, 0, 24);
        play(4, "disp");

        // Max column SAD 1020, window 4080; still threshold boundary
        i_sad_thr = 12'd4079;
        set_cols(0, 3, 255, 255, 255, 255, 0, 0, 0, 0, 0, 0, 0);
        add_res(5, 4080, 0, 0, 0, 24);
        play(4, "sat_lo");
        i_sad_thr = 12'd4080;
        set_cols(0, 3, 255, 255, 255, 255, 0, 0, 0, 0, 0, 0, 0);
        add_res(5, 4080, 0, 1, 0, 24);
        play(4, "sat_eq");

        // Run break with one-cycle gap: first run W=800, second run W=160
        i_sad_thr = 12'd500;
        set_cols(0, 4, 50, 50, 50, 50, 0, 0, 0, 0, 0, 0, 0);
        set_cols(6, 10, 50, 50, 50, 50, 40, 40, 40, 40, 40, 40, 40);
        add_res(5, 800, 0, 0, 0, 24);
        add_res(6, 800, 0, 0, 1, 31);
        add_res(11, 160, 0, 1, 0, 66);
        add_res(12, 160, 0, 1, 1, 73);
        play(11, "break");

        // Partial window: no result
        set_cols(0, 2, 9, 9, 9, 9, 1, 2, 3, 4, 5, 6, 7);
        play(3, "short");

        // Sliding: p1 = 4,4,4,4 then 100; other offsets 50 each column
        i_sad_thr = 12'd100;
        set_cols(0, 3, 0, 0, 0, 0, 47, 1, 1, 1, 1, 47, 1);
        set_cols(4, 4, 0, 0, 0, 0, 0, 50, 0, 0, 50, 0, 0);
        add_res(5, 16, 1, 1, 0, 24);
        add_res(6, 112, 1, 0, 1, 31);
        play(5, "slide");
        chk("hold.min", 32'(o_sad_min), 112);
        chk("hold.mv", 32'(o_mv_y), 1);
        chk("hold.still", 32'(o_still), 0);
        chk("hold.idx", 32'(o_col_idx), 1);
        chk("hold.pix", 32'(o_out_pix), 31);

        // Reset during the third column of a run
        set_cols(0, 2, 255, 255, 255, 255, 0, 0, 0, 0, 0, 0, 0);
        drive_col(0); tick();
        drive_col(1); tick();
        drive_col(2);
        #2;
        nrst = 1'b0;
        drive_idle();
        #1;
        chk_zero("midrst");
        #2;
        nrst = 1'b1;
        clr();
        i_sad_thr = 12'd0;
        // p = 0,70,110,120 -> fresh window gives W0 = 0
        set_cols(0, 3, 10, 20, 30, 40, 10, 20, 30, 40, 0, 0, 0);
        add_res(5, 0, 0, 1, 0, 24);
        play(4, "postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
